if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the MIPS64 pipeline. Sits directly upstream of the ID decoder.
- Owns the PC and fetches each 32-bit instruction as four byte reads over a req/ack memory port. Bytes are assembled big-endian.
- Presents {inst, inst_pc} to ID over a valid/ready handshake. Accepts PC redirects from EX for branches and jumps.

Parameters:
- PC_L, 32, PC width.
- MADDR_L, 32, memory byte-address width (PC_L >= MADDR_L; mem_addr = pc[MADDR_L-1:0]+cnt).
- INST_L, 32, instruction width (fixed 4 bytes).
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  byte read request.
- mem_addr  out  MADDR_L  byte address of current request.
- mem_ack  in  1  read done; mem_data valid this cycle.
- mem_data  in  8  returned byte.
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  PC_L  new PC.
- inst_valid  out  1  instruction available to ID.
- inst_ready  in  1  ID accepts instruction.
- inst  out  INST_L  fetched instruction.
- inst_pc  out  PC_L  address of inst.
- busy  out  1  fetch in progress (state FETCH).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: pc=RESET_PC, cnt=0, state=FETCH, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, busy=0.
  - mem_req first rises on the first clk edge after rst_n deasserts.
  - Reset asserted mid-fetch or mid-hold drops all outputs to reset values immediately.
- State FETCH:
  - mem_req=1 continuously; mem_addr=pc+cnt; busy=1.
  - Each cycle with mem_ack=1, mem_data is captured into byte lane (3-cnt): cnt0 -> inst[31:24], cnt3 -> inst[7:0]. cnt then increments.
  - mem_ack may arrive the same cycle as mem_req or any later cycle. mem_ack while mem_req=0 is ignored.
  - On the 4th ack: register inst and inst_pc=pc, set inst_valid=1 next cycle, cnt=0, go to HOLD.
  - Latency with zero-wait memory: 4 cycles from first mem_req to inst_valid.
- State HOLD:
  - mem_req=0, busy=0.
  - inst and inst_pc stay stable while inst_valid && !inst_ready.
  - On inst_valid && inst_ready: pc<=pc+4, inst_valid<=0, go to FETCH.
- PC arithmetic: modulo 2^PC_L. Wraps silently from 32'hFFFF_FFFC to 0. Byte address pc+cnt also wraps.
- Redirect (highest priority, any state):
  - pc<=redirect_pc with bits[1:0] forced to 0; cnt<=0; partial bytes discarded; inst_valid<=0; state<=FETCH.
  - A mem_ack in the same cycle as redirect is dropped.
  - redirect with inst_valid && inst_ready in the same cycle: the handshake completes (ID consumed the instruction), then the redirect wins and no pc+4 is applied.
  - Back-to-back redirects: the last one wins.

Optional Feature:
- Macro: IF_QUEUE_EN.
- Defined:
  - 2-entry FIFO of {inst, inst_pc} between fetch and ID.
  - FETCH continues while the FIFO is not full; pc advances by 4 as each instruction completes, not on handshake. HOLD is entered only when the FIFO is full.
  - inst_valid = FIFO not empty; inst/inst_pc = head entry.
  - Enqueue and dequeue may occur in the same cycle (count unchanged).
  - Redirect flushes both entries.
  - Zero-wait memory with ID always ready: one instruction per 4 cycles sustained.
- Undefined:
  - Single holding register. No fetch overlap, per the HOLD state above.
  - Throughput: one instruction per 4 fetch cycles + 1 handshake cycle.

Test Plan:
- Reset release, memory bytes at 0..3 = 8'h20,8'h01,8'h00,8'h05, zero-wait ack, inst_ready=1 -> mem_addr sequence 0,1,2,3; inst=32'h2001_0005, inst_pc=0, inst_valid high 1 cycle; next mem_addr=4.
- ack delayed 3 cycles per byte -> mem_addr holds each value until ack; inst assembled correctly; busy=1 throughout fetch.
- inst_ready=0 for 5 cycles after inst_valid -> inst/inst_pc unchanged, mem_req=0 (queue-off) or fetch of pc+4 completes then stalls (IF_QUEUE_EN), no lost or duplicated instruction.
- redirect pulse with redirect_pc=32'h0000_0103 after 2nd byte ack -> partial discarded; next mem_addr=32'h100; inst_pc of next instruction=32'h100.
- RESET_PC=32'hFFFF_FFFC, one fetch and handshake -> mem_addr FFFF_FFFC..FFFF_FFFF, then pc wraps to 0.
- rst_n low for 1 cycle during 3rd byte -> mem_req/inst_valid low asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: four big-endian byte reads per 32-bit instruction, valid/ready to ID.
// Define IF_QUEUE_EN to add a 2-entry instruction FIFO that lets fetch run ahead of ID.
module if_fetch_unit #(
    parameter int unsigned     PC_L     = 32,
    parameter int unsigned     MADDR_L  = 32,
    parameter int unsigned     INST_L   = 32,
    parameter logic [PC_L-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req_o,
    output logic [MADDR_L-1:0] mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [7:0]         mem_data_i,
    input  logic               redirect_i,
    input  logic [PC_L-1:0]    redirect_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [INST_L-1:0]  inst_o,
    output logic [PC_L-1:0]    inst_pc_o,
    output logic               busy_o
);
    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e              state_q, state_d;
    logic [PC_L-1:0]     pc_q, pc_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [INST_L-9:0]   asm_q, asm_d;
    logic                run_q;
    logic                ack_ok;
    logic                last_ack;
    logic [INST_L-1:0]   fetched_word;
    logic [PC_L-1:0]     redirect_pc_al;

    // run_q holds mem_req low until the first edge after reset release.
    assign mem_req_o      = run_q && (state_q == StFetch);
    assign busy_o         = mem_req_o;
    assign mem_addr_o     = pc_q[MADDR_L-1:0] + MADDR_L'(cnt_q);
    assign ack_ok         = mem_req_o && mem_ack_i && !redirect_i;
    assign last_ack       = ack_ok && (cnt_q == 2'd3);
    assign fetched_word   = {asm_q, mem_data_i};
    assign redirect_pc_al = redirect_pc_i & ~PC_L'(3);

    // Bytes shift in from the right, so the first byte ends up in the top lane.
    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (redirect_i) begin
            cnt_d = '0;
        end else if (ack_ok) begin
            cnt_d = cnt_q + 2'd1;
            asm_d = {asm_q[INST_L-17:0], mem_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            asm_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            run_q   <= 1'b1;
        end
    end

`ifdef IF_QUEUE_EN
    logic [1:0]        count_q, count_d;
    logic              rd_q, rd_d;
    logic              wr_idx, push, pop;
    logic [INST_L-1:0] e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;
    logic [PC_L-1:0]   e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;

    assign push         = last_ack;
    assign pop          = (count_q != 2'd0) && inst_ready_i;
    assign wr_idx       = rd_q ^ count_q[0];
    assign inst_valid_o = (count_q != 2'd0);
    assign inst_o       = rd_q ? e1_inst_q : e0_inst_q;
    assign inst_pc_o    = rd_q ? e1_pc_q : e0_pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        rd_d      = rd_q;
        e0_inst_d = e0_inst_q;
        e1_inst_d = e1_inst_q;
        e0_pc_d   = e0_pc_q;
        e1_pc_d   = e1_pc_q;
        if (redirect_i) begin
            state_d = StFetch;
            pc_d    = redirect_pc_al;
            count_d = '0;
            rd_d    = 1'b0;
        end else begin
            if (pop) begin
                rd_d    = ~rd_q;
                count_d = count_d - 2'd1;
            end
            if (push) begin
                if (wr_idx) begin
                    e1_inst_d = fetched_word;
                    e1_pc_d   = pc_q;
                end else begin
                    e0_inst_d = fetched_word;
                    e0_pc_d   = pc_q;
                end
                count_d = count_d + 2'd1;
                pc_d    = pc_q + PC_L'(4);
            end
            unique case (state_q)
                StFetch: if (push && count_d == 2'd2) state_d = StHold;
                StHold:  if (pop) state_d = StFetch;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            rd_q      <= 1'b0;
            e0_inst_q <= '0;
            e1_inst_q <= '0;
            e0_pc_q   <= '0;
            e1_pc_q   <= '0;
        end else begin
            count_q   <= count_d;
            rd_q      <= rd_d;
            e0_inst_q <= e0_inst_d;
            e1_inst_q <= e1_inst_d;
            e0_pc_q   <= e0_pc_d;
            e1_pc_q   <= e1_pc_d;
        end
    end
`else
    logic              valid_q, valid_d;
    logic [INST_L-1:0] inst_q, inst_d;
    logic [PC_L-1:0]   ipc_q, ipc_d;

    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = ipc_q;

    // Redirect wins over a same-cycle handshake: the instruction is consumed, no pc+4.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        if (redirect_i) begin
            state_d = StFetch;
            pc_d    = redirect_pc_al;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (last_ack) begin
                        inst_d  = fetched_word;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (valid_q && inst_ready_i) begin
                        pc_d    = pc_q + PC_L'(4);
                        valid_d = 1'b0;
                        state_d = StFetch;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            ipc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed steps plus a randomized phase checked against an
// instruction-stream model (expected next PC, bytes from a fixed memory function).
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_req, mem_ack, redirect, inst_valid, inst_ready, busy;
    logic [31:0] mem_addr, redirect_pc, inst, inst_pc;
    logic [7:0]  mem_data;
    logic        w_req, w_valid, w_busy;
    logic [31:0] w_addr, w_inst, w_inst_pc;
    logic [7:0]  w_data;

    int checks = 0;
    int errors = 0;
    int n_hs   = 0;
    logic [31:0] exp_pc, wexp;

    int unsigned wcnt    = 0;
    int unsigned rnd_lat = 0;
    int unsigned lat_max = 0;
    int unsigned eff_lat;
    bit          lat_rand  = 1'b0;
    bit          force_ack = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h20;
            32'd1:   return 8'h01;
            32'd2:   return 8'h00;
            32'd3:   return 8'h05;
            default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
    endfunction

    if_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .busy_o       (busy)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req_o    (w_req),
        .mem_addr_o   (w_addr),
        .mem_ack_i    (w_req),
        .mem_data_i   (w_data),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0),
        .inst_valid_o (w_valid),
        .inst_ready_i (1'b1),
        .inst_o       (w_inst),
        .inst_pc_o    (w_inst_pc),
        .busy_o       (w_busy)
    );

    // Memory responder: ack after eff_lat wait cycles per byte.
    assign eff_lat  = lat_rand ? rnd_lat : lat_max;
    assign mem_ack  = (mem_req && (wcnt >= eff_lat)) || force_ack;
    assign mem_data = mem_byte(mem_addr);
    assign w_data   = mem_byte(w_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
        if (mem_req && mem_ack) rnd_lat <= $urandom_range(0, lat_max);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: every accepted instruction must be the next word in program order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc <= 32'h0;
            wexp   <= 32'hFFFF_FFFC;
        end else begin
            if (inst_valid && inst_ready) begin
                chk("sb_inst", inst, word_at(exp_pc));
                chk("sb_inst_pc", inst_pc, exp_pc);
                exp_pc <= exp_pc + 32'd4;
                n_hs   <= n_hs + 1;
            end
            if (redirect) exp_pc <= redirect_pc & ~32'd3;
            if (w_valid) begin
                chk("wrap_inst_pc", w_inst_pc, wexp);
                chk("wrap_inst", w_inst, word_at(wexp));
                wexp <= wexp + 32'd4;
            end
        end
    end

    initial begin
        rst_n = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);
        tick(); tick();
        rst_n = 1'b1;
        chk1("req_before_edge", mem_req, 1'b0);

        // Zero-wait fetch of the first instruction
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_addr", mem_addr, i);
            chk1("t1_req", mem_req, 1'b1);
            chk("t1_w_addr", w_addr, 32'hFFFF_FFFC + i);
        end
        tick();
        chk1("t1_valid", inst_valid, 1'b1);
        chk("t1_inst", inst, 32'h2001_0005);
        chk("t1_inst_pc", inst_pc, 32'h0);
        chk("t1_w_inst_pc", w_inst_pc, 32'hFFFF_FFFC);
`ifdef IF_QUEUE_EN
        chk("t1_next_addr", mem_addr, 32'h4);
        chk("t1_w_next_addr", w_addr, 32'h0);
`else
        chk1("t1_hold_req", mem_req, 1'b0);
`endif
        tick();
        chk1("t1_valid_pulse", inst_valid, 1'b0);
`ifndef IF_QUEUE_EN
        chk("t1_next_addr", mem_addr, 32'h4);
        chk1("t1_next_req", mem_req, 1'b1);
        chk("t1_w_next_addr", w_addr, 32'h0);
`endif

        // Three wait cycles per byte, ID not ready
        rst_n = 1'b0;
        lat_max = 3;
        inst_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("t2_addr", mem_addr, b);
                chk1("t2_busy", busy, 1'b1);
            end
        end
        tick();
        chk1("t2_valid", inst_valid, 1'b1);
        chk("t2_inst", inst, 32'h2001_0005);

        // Stall for 5 cycles; stray acks while idle must be ignored
        for (int i = 0; i < 5; i++) begin
`ifndef IF_QUEUE_EN
            force_ack = 1'b1;
`endif
            tick();
            chk1("t3_valid", inst_valid, 1'b1);
            chk("t3_inst", inst, 32'h2001_0005);
            chk("t3_inst_pc", inst_pc, 32'h0);
`ifdef IF_QUEUE_EN
            chk1("t3_req", mem_req, 1'b1);
`else
            chk1("t3_req", mem_req, 1'b0);
            chk1("t3_busy", busy, 1'b0);
`endif
        end
        force_ack = 1'b0;
        inst_ready = 1'b1;
        tick();
        chk1("t3_consumed", inst_valid, 1'b0);

        // Random ready, latency and redirects
        lat_rand = 1'b1;
        lat_max = 2;
        for (int i = 0; i < 3000; i++) begin
            inst_ready  = ($urandom_range(0, 99) < 70);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0;
        inst_ready = 1'b1;
        chk1("rand_progress", n_hs > 50, 1'b1);

        // Redirect after the second byte ack
        rst_n = 1'b0;
        lat_rand = 1'b0;
        lat_max = 0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t4_addr_byte2", mem_addr, 32'h2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("t4_addr_0", mem_addr, 32'h100);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t4_addr", mem_addr, 32'h100 + i);
        end
        tick();
        chk1("t4_valid", inst_valid, 1'b1);
        chk("t4_inst_pc", inst_pc, 32'h100);
        chk("t4_inst", inst, word_at(32'h100));

        // Asynchronous reset during the third byte
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("t6_addr_byte2", mem_addr, 32'h2);
        chk1("t6_req_before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("t6_req_async", mem_req, 1'b0);
        chk1("t6_valid_async", inst_valid, 1'b0);
        chk1("t6_busy_async", busy, 1'b0);
        chk("t6_addr_async", mem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        chk1("t6_req_released", mem_req, 1'b0);
        tick();
        chk1("t6_req_restart", mem_req, 1'b1);
        chk("t6_addr_restart", mem_addr, 32'h0);
        for (int i = 0; i < 8; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
